rt_proc_tx: RTL

//  Clocked network interface that injects flits into a router's asynchronous proc input.

---
 rtl/router_pkg.sv | 26 ++
 rtl/RTPort.sv | 12 +
 rtl/rt_flit_fifo.sv | 40 ++++
 rtl/rt_proc_tx.sv | 117 +++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router network interfaces.
// Coordinate helpers take widened operands so one definition serves every mesh size.
package router_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} tx_state_e;

  // Widest coordinate the helpers accept; callers zero-extend into this.
  localparam int HW = 16;

  function automatic int coord_w(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

  // Direction bits {dirx, diry}: set when the destination lies above the source.
  function automatic logic [1:0] hdr_build(input logic [HW-1:0] dstx,
                                           input logic [HW-1:0] dsty,
                                           input logic [HW-1:0] srcx,
                                           input logic [HW-1:0] srcy);
    return {dstx > srcx, dsty > srcy};
  endfunction

  function automatic logic in_range(input logic [HW-1:0] v, input logic [HW-1:0] max);
    return v <= max;
  endfunction

endpackage

// File: rtl/RTPort.sv
// Two-phase bundled-data channel shared with the Corner_Router ports.
// Output side drives req/data and samples ack; Input side is the mirror.
interface RTPort #(
  parameter int n = 32
) ();
  logic         req;
  logic [n-1:0] data;
  logic         ack;

  modport Output (output req, output data, input ack);
  modport Input  (input req, input data, output ack);
endinterface

// File: rtl/rt_flit_fifo.sv
// Synchronous flit FIFO; pointers carry one wrap bit to tell full from empty.
module rt_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rt_proc_tx.sv
// Clocked injector into a router proc input: builds the routing header, queues flits
// and drives them over the two-phase req/ack channel, one toggle per flit.
module rt_proc_tx
  import router_pkg::*;
#(
  parameter int n     = 32,
  parameter int srcx  = 0,
  parameter int srcy  = 0,
  parameter int maxx  = 1,
  parameter int maxy  = 1,
  parameter int DEPTH = 4,
  localparam int XW   = coord_w(maxx),
  localparam int YW   = coord_w(maxy),
  localparam int PW   = n - XW - YW - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [XW-1:0] s_dstx,
  input  logic [YW-1:0] s_dsty,
  input  logic [PW-1:0] s_payload,
  RTPort.Output         tx,
  output logic          busy,
  output logic          err,
  output logic [15:0]   sent_cnt
);
  // Field widths follow the module parameters, so the flit layout lives here.
  typedef struct packed {
    logic [XW-1:0] dstx;
    logic [YW-1:0] dsty;
    logic          dirx;
    logic          diry;
    logic [PW-1:0] payload;
  } rt_flit_t;

  rt_flit_t     in_flit;
  logic [n-1:0] head, data_q;
  logic         full, empty, push, pop, accept, dst_ok;
  logic         req_q, ack_m, ack_s;
  logic         load, toggle, done;
  tx_state_e    state_q, state_d;

  assign s_ready = rst_n && !full;
  assign accept  = s_valid && s_ready;
  assign dst_ok  = in_range(HW'(s_dstx), HW'(maxx)) && in_range(HW'(s_dsty), HW'(maxy));
  assign push    = accept && dst_ok;
  assign busy    = !empty || (state_q != IDLE);

  always_comb begin
    in_flit.dstx    = s_dstx;
    in_flit.dsty    = s_dsty;
    {in_flit.dirx, in_flit.diry} = hdr_build(HW'(s_dstx), HW'(s_dsty), HW'(srcx), HW'(srcy));
    in_flit.payload = s_payload;
  end

  rt_flit_fifo #(.DEPTH(DEPTH), .W(n)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_flit),
    .full  (full),
    .pop   (pop),
    .rdata (head),
    .empty (empty)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    toggle  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        load    = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        toggle  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (ack_s == req_q) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data is loaded one cycle ahead of the req edge to honour the bundled-data setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      req_q    <= 1'b0;
      ack_m    <= 1'b0;
      ack_s    <= 1'b0;
      err      <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state_q <= state_d;
      ack_m   <= tx.ack;
      ack_s   <= ack_m;
      err     <= accept && !dst_ok;
      if (load)   data_q   <= head;
      if (toggle) req_q    <= ~req_q;
      if (done)   sent_cnt <= sent_cnt + 16'd1;
    end
  end

  assign tx.req  = req_q;
  assign tx.data = data_q;

endmodule
